// File: rtl/dl_pkg.sv
// dl_pkg: shared definitions for the DL bus sequencer.
// Holds the FSM state encoding, the write-strobe length limits, the
// wait-timeout constant and the registered-output bundle.
package dl_pkg;

   // Legal range of the nWR-low strobe length, in cycles
   localparam int unsigned WR_HOLD_MIN = 1;
   localparam int unsigned WR_HOLD_MAX = 15;

   // Number of stalled cycles after which a waited access is aborted
   localparam logic [7:0] WAIT_TIMEOUT = 8'd255;

   // Sequencer states; WAIT_ABORT is the final ack/err cycle of a timed-out access
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      RD_DRIVE   = 3'd1,
      RD_SAMPLE  = 3'd2,
      WR_SETUP   = 3'd3,
      WR_STROBE  = 3'd4,
      WR_END     = 3'd5,
      ALU_LOAD   = 3'd6,
      WAIT_ABORT = 3'd7
   } dl_state_e;

   // Registered control outputs, kept together so they update as one word
   typedef struct packed {
      logic ctrl1;
      logic ctrl2;
      logic nrd;
      logic nwr;
      logic ack;
      logic busy;
      logic err;
   } dl_out_t;

   // Output word while idle: bus disabled, ALU not driving, strobes high
   localparam dl_out_t OUT_IDLE = '{ctrl1: 1'b1, ctrl2: 1'b0, nrd: 1'b1,
                                    nwr: 1'b1, ack: 1'b0, busy: 1'b0, err: 1'b0};

   // Down-counter reload for a strobe of cyc cycles, clamped to the legal range
   function automatic logic [3:0] hold_reload(input int unsigned cyc);
      int unsigned c;
      if (cyc < WR_HOLD_MIN) begin
         c = WR_HOLD_MIN;
      end else if (cyc > WR_HOLD_MAX) begin
         c = WR_HOLD_MAX;
      end else begin
         c = cyc;
      end
      return 4'(c - 32'd1);
   endfunction

endpackage

// File: rtl/dl_seq_timer.sv
// dl_seq_timer: loadable down-counter with a zero flag.
// Used for the write-strobe length and, when enabled, the wait timeout.
module dl_seq_timer #(
   parameter int unsigned W = 4
) (
   input  logic         CLK,
   input  logic         nRESET,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_q;

   // Next count: load has priority over decrement, otherwise hold
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec) begin
         cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register, cleared by reset
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/dl_bus_seq.sv
// dl_bus_seq: sequences external-bus reads, writes and ALU loads onto DL.
// Optional feature macro: DL_SEQ_WAIT_EN adds the nWAIT input, stalls in
// RD_DRIVE/WR_STROBE while nWAIT is low, and aborts with ack+err after
// 255 stalled cycles. Without it err is constant 0.
// All outputs are registered from the next-state decode.
module dl_bus_seq
   import dl_pkg::*;
#(
   parameter int unsigned WR_HOLD_CYC = 1
) (
   input  logic       CLK,
   input  logic       nRESET,
   input  logic       req_rd,
   input  logic       req_wr,
   input  logic       req_alu,
   input  logic [7:0] DL,
`ifdef DL_SEQ_WAIT_EN
   input  logic       nWAIT,
`endif
   output logic       ack,
   output logic       busy,
   output logic [7:0] rd_data,
   output logic       DL_Control1,
   output logic       DL_Control2,
   output logic       nRD,
   output logic       nWR,
   output logic       err
);

   localparam logic [3:0] HOLD_RELOAD = hold_reload(WR_HOLD_CYC);
`ifdef DL_SEQ_WAIT_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   dl_state_e  state_q, state_d;
   dl_out_t    out_q, out_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       stall_s, timeout_s;
   logic       hold_zero_s, hold_load_s, hold_dec_s;

   // Strobe timer: reloaded outside WR_STROBE, counts down while not stalled
   assign hold_load_s = (state_q != WR_STROBE);
   assign hold_dec_s  = (state_q == WR_STROBE) && !stall_s && !hold_zero_s;

   dl_seq_timer #(.W(4)) u_hold_timer (
      .CLK      (CLK),
      .nRESET   (nRESET),
      .load     (hold_load_s),
      .load_val (HOLD_RELOAD),
      .dec      (hold_dec_s),
      .zero     (hold_zero_s)
   );

`ifdef DL_SEQ_WAIT_EN
   logic wait_st_s, wait_zero_s, wait_load_s, wait_dec_s;

   // Wait timer counts stalled cycles across the whole access; the 255th stall aborts
   assign wait_st_s   = (state_q == RD_DRIVE) || (state_q == WR_STROBE);
   assign stall_s     = wait_st_s && !nWAIT;
   assign wait_load_s = !wait_st_s;
   assign wait_dec_s  = stall_s && !wait_zero_s;
   assign timeout_s   = stall_s && wait_zero_s;

   dl_seq_timer #(.W(8)) u_wait_timer (
      .CLK      (CLK),
      .nRESET   (nRESET),
      .load     (wait_load_s),
      .load_val (WAIT_TIMEOUT - 8'd1),
      .dec      (wait_dec_s),
      .zero     (wait_zero_s)
   );
`else
   assign stall_s   = 1'b0;
   assign timeout_s = 1'b0;
`endif

   // State register
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: requests are only looked at in IDLE, alu > wr > rd
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_alu) begin
               state_d = ALU_LOAD;
            end else if (req_wr) begin
               state_d = WR_SETUP;
            end else if (req_rd) begin
               state_d = RD_DRIVE;
            end else begin
               state_d = IDLE;
            end
         end
         RD_DRIVE: begin
            if (timeout_s) begin
               state_d = WAIT_ABORT;
            end else if (stall_s) begin
               state_d = RD_DRIVE;
            end else begin
               state_d = RD_SAMPLE;
            end
         end
         WR_SETUP:  state_d = WR_STROBE;
         WR_STROBE: begin
            if (timeout_s) begin
               state_d = WAIT_ABORT;
            end else if (stall_s || !hold_zero_s) begin
               state_d = WR_STROBE;
            end else begin
               state_d = WR_END;
            end
         end
         RD_SAMPLE:  state_d = IDLE;
         WR_END:     state_d = IDLE;
         ALU_LOAD:   state_d = IDLE;
         WAIT_ABORT: state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // Output decode of the state being entered, so outputs come straight from flops
   always_comb begin
      out_d = OUT_IDLE;
      case (state_d)
         IDLE: out_d = OUT_IDLE;
         RD_DRIVE: begin
            out_d.ctrl1 = 1'b0;
            out_d.nrd   = 1'b0;
            out_d.busy  = 1'b1;
         end
         RD_SAMPLE: begin
            out_d.ctrl1 = 1'b0;
            out_d.nrd   = 1'b0;
            out_d.ack   = 1'b1;
            out_d.busy  = 1'b1;
         end
         WR_SETUP: begin
            out_d.ctrl1 = 1'b0;
            out_d.busy  = 1'b1;
         end
         WR_STROBE: begin
            out_d.ctrl1 = 1'b0;
            out_d.nwr   = 1'b0;
            out_d.busy  = 1'b1;
         end
         WR_END: begin
            out_d.ctrl1 = 1'b0;
            out_d.ack   = 1'b1;
            out_d.busy  = 1'b1;
         end
         ALU_LOAD: begin
            out_d.ctrl2 = 1'b1;
            out_d.ack   = 1'b1;
            out_d.busy  = 1'b1;
         end
         WAIT_ABORT: begin
            out_d.ack  = 1'b1;
            out_d.busy = 1'b1;
            out_d.err  = ERR_EN;
         end
         default: out_d = OUT_IDLE;
      endcase
   end

   // Read capture: DL is latched only on the edge into RD_SAMPLE
   always_comb begin
      if (state_d == RD_SAMPLE) begin
         rd_data_d = DL;
      end else begin
         rd_data_d = rd_data_q;
      end
   end

   // Output registers; reset aborts any access without an ack
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         out_q     <= OUT_IDLE;
         rd_data_q <= 8'h00;
      end else begin
         out_q     <= out_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign ack         = out_q.ack;
   assign busy        = out_q.busy;
   assign err         = out_q.err;
   assign DL_Control1 = out_q.ctrl1;
   assign DL_Control2 = out_q.ctrl2;
   assign nRD         = out_q.nrd;
   assign nWR         = out_q.nwr;
   assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_dl_bus_seq.sv
// tb_dl_bus_seq: self-checking bench for dl_bus_seq (WR_HOLD_CYC = 3).
// A transaction-level model expands each accepted request into its expected
// per-cycle output waveform; directed tasks check latencies and corner cases.
// Build with DL_SEQ_WAIT_EN to include the wait-timeout scenario.
module tb_dl_bus_seq;

   localparam int HOLD = 3;

   logic       CLK = 1'b0;
   logic       nRESET;
   logic       req_rd, req_wr, req_alu;
   logic [7:0] DL;
   logic       nWAIT;
   logic       ack, busy, DL_Control1, DL_Control2, nRD, nWR, err;
   logic [7:0] rd_data;

   int n_checks = 0;
   int n_pass   = 0;

   dl_bus_seq #(.WR_HOLD_CYC(HOLD)) dut (
      .CLK         (CLK),
      .nRESET      (nRESET),
      .req_rd      (req_rd),
      .req_wr      (req_wr),
      .req_alu     (req_alu),
      .DL          (DL),
`ifdef DL_SEQ_WAIT_EN
      .nWAIT       (nWAIT),
`endif
      .ack         (ack),
      .busy        (busy),
      .rd_data     (rd_data),
      .DL_Control1 (DL_Control1),
      .DL_Control2 (DL_Control2),
      .nRD         (nRD),
      .nWR         (nWR),
      .err         (err)
   );

   always #5 CLK = ~CLK;

   // ---------------- transaction-level reference model ----------------
   typedef struct packed {
      logic c1; logic c2; logic nrd; logic nwr; logic ack; logic busy; logic err;
   } vec_t;

   localparam vec_t V_IDLE = '{c1: 1'b1, c2: 1'b0, nrd: 1'b1, nwr: 1'b1,
                               ack: 1'b0, busy: 1'b0, err: 1'b0};

   vec_t       exp_q[$];
   bit         cap_q[$];
   vec_t       exp_now;
   logic [7:0] exp_rd;

   function automatic vec_t mk(input logic c1, input logic c2, input logic nrd,
                               input logic nwr, input logic a, input logic b);
      vec_t v;
      v.c1 = c1; v.c2 = c2; v.nrd = nrd; v.nwr = nwr; v.ack = a; v.busy = b; v.err = 1'b0;
      return v;
   endfunction

   function automatic void push(input vec_t v, input bit cap);
      exp_q.push_back(v);
      cap_q.push_back(cap);
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      cap_q.delete();
      exp_now = V_IDLE;
      exp_rd  = 8'h00;
   endfunction

   // One clock edge: when idle, an accepted request becomes its whole waveform
   // (operation cycles followed by the mandatory idle cycle).
   function automatic void model_edge(input logic alu, input logic wr, input logic rd,
                                      input logic [7:0] dl);
      if (exp_q.size() == 0) begin
         if (alu) begin
            push(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1), 1'b0);
            push(V_IDLE, 1'b0);
         end else if (wr) begin
            push(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0);
            for (int i = 0; i < HOLD; i++) push(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0);
            push(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1), 1'b0);
            push(V_IDLE, 1'b0);
         end else if (rd) begin
            push(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0);
            push(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1), 1'b1);
            push(V_IDLE, 1'b0);
         end
      end
      if (exp_q.size() > 0) begin
         exp_now = exp_q.pop_front();
         if (cap_q.pop_front()) exp_rd = dl;
      end else begin
         exp_now = V_IDLE;
      end
   endfunction

   // Model advances on the same edges as the DUT, and is cleared by reset
   always @(posedge CLK or negedge nRESET) begin
      if (!nRESET) model_reset();
      else         model_edge(req_alu, req_wr, req_rd, DL);
   end

   function automatic vec_t obs();
      vec_t v;
      v = {DL_Control1, DL_Control2, nRD, nWR, ack, busy, err};
      return v;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      nRESET = 1'b0; req_rd = 1'b0; req_wr = 1'b0; req_alu = 1'b0; DL = 8'h00; nWAIT = 1'b1;
      repeat (2) @(negedge CLK);
      n_checks++;
      if (obs() !== V_IDLE) $display("FAIL reset_outputs: observed %b, expected %b", obs(), V_IDLE);
      else n_pass++;
      n_checks++;
      if (rd_data !== 8'h00) $display("FAIL reset_rd_data: observed %h, expected %h", rd_data, 8'h00);
      else n_pass++;
      nRESET = 1'b1;
   endtask

   task automatic test_read();
      int nrd_low = 0;
      int ack_cyc = 0;
      req_rd = 1'b1; DL = 8'hA5;
      for (int c = 1; c <= 6; c++) begin
         @(negedge CLK);
         if (nRD === 1'b0) nrd_low++;
         if (ack === 1'b1) begin
            ack_cyc = c;
            req_rd  = 1'b0;
         end
      end
      n_checks++;
      if (nrd_low != 2) $display("FAIL read_nrd_len: observed %0d, expected %0d", nrd_low, 2);
      else n_pass++;
      n_checks++;
      if (ack_cyc != 2) $display("FAIL read_ack_cycle: observed %0d, expected %0d", ack_cyc, 2);
      else n_pass++;
      n_checks++;
      if (rd_data !== 8'hA5) $display("FAIL read_data: observed %h, expected %h", rd_data, 8'hA5);
      else n_pass++;
   endtask

   task automatic test_drop();
      logic [7:0] v;
      int acks = 0;
      v = 8'($urandom);
      req_rd = 1'b1; DL = v;
      @(negedge CLK);
      req_rd = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         if (ack === 1'b1) acks++;
      end
      n_checks++;
      if (acks != 1) $display("FAIL drop_ack_count: observed %0d, expected %0d", acks, 1);
      else n_pass++;
      n_checks++;
      if (rd_data !== v) $display("FAIL drop_rd_data: observed %h, expected %h", rd_data, v);
      else n_pass++;
   endtask

   task automatic test_write();
      int nwr_low = 0, first = 0, last = 0, ack_cyc = 0, c1_low = 0;
      req_wr = 1'b1; DL = 8'h3C;
      for (int c = 1; c <= 8; c++) begin
         @(negedge CLK);
         req_wr = 1'b0;
         if (nWR === 1'b0) begin
            nwr_low++;
            if (first == 0) first = c;
            last = c;
         end
         if (DL_Control1 === 1'b0) c1_low++;
         if (ack === 1'b1) ack_cyc = c;
      end
      n_checks++;
      if (nwr_low != HOLD) $display("FAIL write_nwr_len: observed %0d, expected %0d", nwr_low, HOLD);
      else n_pass++;
      n_checks++;
      if (last - first + 1 != HOLD)
         $display("FAIL write_nwr_contig: observed span %0d, expected %0d", last - first + 1, HOLD);
      else n_pass++;
      n_checks++;
      if (ack_cyc != HOLD + 2) $display("FAIL write_ack_cycle: observed %0d, expected %0d", ack_cyc, HOLD + 2);
      else n_pass++;
      n_checks++;
      if (c1_low != HOLD + 2) $display("FAIL write_ctrl1_low: observed %0d, expected %0d", c1_low, HOLD + 2);
      else n_pass++;
   endtask

   task automatic test_priority();
      int kinds[$];
      int ats[$];
      logic busy_at [0:15];
      req_alu = 1'b1; req_wr = 1'b1; req_rd = 1'b1; DL = 8'h96;
      for (int c = 1; c <= 14; c++) begin
         @(negedge CLK);
         busy_at[c] = busy;
         n_checks++;
         if (obs() !== exp_now) $display("FAIL priority_wave c%0d: observed %b, expected %b", c, obs(), exp_now);
         else n_pass++;
         if (ack === 1'b1) begin
            ats.push_back(c);
            if (DL_Control2 === 1'b1) begin kinds.push_back(1); req_alu = 1'b0; end
            else if (nRD === 1'b0)    begin kinds.push_back(3); req_rd  = 1'b0; end
            else                      begin kinds.push_back(2); req_wr  = 1'b0; end
         end
      end
      req_alu = 1'b0; req_wr = 1'b0; req_rd = 1'b0;
      n_checks++;
      if (kinds.size() != 3 || kinds[0] != 1 || kinds[1] != 2 || kinds[2] != 3)
         $display("FAIL priority_order: observed %p, expected '{1, 2, 3}", kinds);
      else n_pass++;
      n_checks++;
      if (ats.size() != 3 || ats[0] != 1 || ats[1] != HOLD + 4 || ats[2] != HOLD + 7)
         $display("FAIL priority_ack_cycles: observed %p, expected 1 %0d %0d", ats, HOLD + 4, HOLD + 7);
      else n_pass++;
      n_checks++;
      if (busy_at[2] !== 1'b0 || busy_at[3] !== 1'b1 || busy_at[HOLD + 5] !== 1'b0 || busy_at[HOLD + 6] !== 1'b1)
         $display("FAIL priority_idle_gap: observed %b%b%b%b, expected 0101",
                  busy_at[2], busy_at[3], busy_at[HOLD + 5], busy_at[HOLD + 6]);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         @(negedge CLK);
         n_checks++;
         if (obs() !== exp_now) $display("FAIL random_wave c%0d: observed %b, expected %b", c, obs(), exp_now);
         else n_pass++;
         n_checks++;
         if (rd_data !== exp_rd) $display("FAIL random_rd_data c%0d: observed %h, expected %h", c, rd_data, exp_rd);
         else n_pass++;
         n_checks++;
         if ((nRD === 1'b0 && nWR === 1'b0) || (DL_Control2 === 1'b1 && DL_Control1 === 1'b0))
            $display("FAIL random_exclusive c%0d: observed nRD=%b nWR=%b c1=%b c2=%b, expected no overlap",
                     c, nRD, nWR, DL_Control1, DL_Control2);
         else n_pass++;
         req_alu = ($urandom_range(0, 7) == 0);
         req_wr  = ($urandom_range(0, 3) == 0);
         req_rd  = ($urandom_range(0, 2) == 0);
         DL      = 8'($urandom);
      end
      req_alu = 1'b0; req_wr = 1'b0; req_rd = 1'b0;
      repeat (10) @(negedge CLK);
   endtask

   task automatic test_async_reset();
      bit found = 1'b0;
      int acks = 0;
      req_wr = 1'b1;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge CLK);
         req_wr = 1'b0;
         if (nWR === 1'b0) found = 1'b1;
      end
      n_checks++;
      if (!found) $display("FAIL arst_reach_strobe: observed no nWR low, expected nWR low within 10 cycles");
      else n_pass++;
      #2 nRESET = 1'b0;
      #1;
      n_checks++;
      if (nWR !== 1'b1 || DL_Control1 !== 1'b1 || busy !== 1'b0 || ack !== 1'b0)
         $display("FAIL arst_immediate: observed nWR=%b c1=%b busy=%b ack=%b, expected 1 1 0 0",
                  nWR, DL_Control1, busy, ack);
      else n_pass++;
      req_wr = 1'b1;
      repeat (2) begin
         @(negedge CLK);
         if (ack !== 1'b0) acks++;
      end
      n_checks++;
      if (acks != 0) $display("FAIL arst_no_ack: observed %0d acks, expected 0", acks);
      else n_pass++;
      n_checks++;
      if (obs() !== V_IDLE) $display("FAIL arst_held: observed %b, expected %b", obs(), V_IDLE);
      else n_pass++;
      nRESET = 1'b1; req_wr = 1'b0; req_rd = 1'b1; DL = 8'h5A;
      @(negedge CLK);
      n_checks++;
      if (busy !== 1'b1 || nRD !== 1'b0) $display("FAIL resume_accept: observed busy=%b nRD=%b, expected 1 0", busy, nRD);
      else n_pass++;
      req_rd = 1'b0;
      repeat (3) @(negedge CLK);
      n_checks++;
      if (rd_data !== 8'h5A) $display("FAIL resume_rd_data: observed %h, expected %h", rd_data, 8'h5A);
      else n_pass++;
   endtask

`ifdef DL_SEQ_WAIT_EN
   task automatic test_wait();
      logic [7:0] prior;
      int nrd_low = 0, acks = 0, errs = 0, ack_cyc = 0;
      logic strobes_at_ack = 1'b0;
      logic err_at_ack = 1'b0;
      prior = exp_rd;
      nWAIT = 1'b0; req_rd = 1'b1; DL = ~prior;
      for (int c = 1; c <= 300; c++) begin
         @(negedge CLK);
         req_rd = 1'b0;
         if (nRD === 1'b0) nrd_low++;
         if (err === 1'b1) errs++;
         if (ack === 1'b1) begin
            acks++;
            ack_cyc = c;
            strobes_at_ack = nRD & nWR;
            err_at_ack = err;
         end
      end
      nWAIT = 1'b1;
      repeat (4) @(negedge CLK);
      n_checks++;
      if (nrd_low != 255) $display("FAIL wait_stall_len: observed %0d, expected %0d", nrd_low, 255);
      else n_pass++;
      n_checks++;
      if (acks != 1 || ack_cyc != 256) $display("FAIL wait_ack: observed %0d acks at %0d, expected 1 at 256", acks, ack_cyc);
      else n_pass++;
      n_checks++;
      if (errs != 1 || err_at_ack !== 1'b1) $display("FAIL wait_err: observed %0d errs, at_ack=%b, expected 1 1", errs, err_at_ack);
      else n_pass++;
      n_checks++;
      if (strobes_at_ack !== 1'b1) $display("FAIL wait_strobes: observed %b, expected 1", strobes_at_ack);
      else n_pass++;
      n_checks++;
      if (rd_data !== prior) $display("FAIL wait_rd_data: observed %h, expected %h", rd_data, prior);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_read();
      test_drop();
      test_write();
      test_priority();
      test_random();
      test_async_reset();
`ifdef DL_SEQ_WAIT_EN
      test_wait();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
